// File: rtl/seg7_decoder_if.sv
// Digit delivery handshake for seg7_decoder: the decoder drives bcd/out_valid
// and the consumer drives out_ready. A digit transfers on out_valid && out_ready.
interface seg7_decoder_if;
    logic [3:0] bcd;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output bcd,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  bcd,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/seg7_decoder.sv
// seg7_decoder: recovers a BCD digit from an active-low seven-segment pattern
// (bit 6 = g ... bit 0 = a). A pattern must be seen on STABLE_CYCLES
// consecutive edges before it is accepted, and each stable run is accepted
// exactly once. Legal digits are offered over the dig handshake. Illegal
// patterns pulse 'invalid' and bump a saturating error counter. A digit that
// arrives while a previous one is still stalled is dropped and sets the sticky
// 'overrun' flag.
// Build option: define SEG7_DECODER_HEX_EN to also accept the hex letters
// A, b, C, d, E, F (decoded as 10..15); otherwise they count as illegal.
module seg7_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       leds,
    seg7_decoder_if.master   dig,
    output logic             invalid,
    output logic [CNT_W-1:0] err_count,
    output logic             overrun
);

    localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_ZERO = {RUN_W{1'b0}};
    localparam logic [RUN_W-1:0] RUN_ONE  = {{(RUN_W-1){1'b0}}, 1'b1};
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STABLE_CYCLES);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [6:0]       BLANK    = 7'b1111111;

    // Pattern lookup; returns {legal, digit}. Blank is reported as not legal
    // and is filtered separately by the caller.
    function automatic logic [4:0] seg_decode(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            7'b1000000: res = {1'b1, 4'd0};
            7'b1111001: res = {1'b1, 4'd1};
            7'b0100100: res = {1'b1, 4'd2};
            7'b0110000: res = {1'b1, 4'd3};
            7'b0011001: res = {1'b1, 4'd4};
            7'b0010010: res = {1'b1, 4'd5};
            7'b0000010: res = {1'b1, 4'd6};
            7'b1111000: res = {1'b1, 4'd7};
            7'b0000000: res = {1'b1, 4'd8};
            7'b0010000: res = {1'b1, 4'd9};
`ifdef SEG7_DECODER_HEX_EN
            7'b0001000: res = {1'b1, 4'd10};
            7'b0000011: res = {1'b1, 4'd11};
            7'b1000110: res = {1'b1, 4'd12};
            7'b0100001: res = {1'b1, 4'd13};
            7'b0000110: res = {1'b1, 4'd14};
            7'b0001110: res = {1'b1, 4'd15};
`endif
            default:    res = {1'b0, 4'd0};
        endcase
        return res;
    endfunction

    logic [6:0]       s_r;
    logic [RUN_W-1:0] run_r;
    logic [3:0]       bcd_r;
    logic             out_valid_r;
    logic             invalid_r;
    logic [CNT_W-1:0] err_count_r;
    logic             overrun_r;

    logic             same_s;
    logic             accept_s;
    logic [RUN_W-1:0] run_nxt_s;
    logic [4:0]       dec_s;
    logic             legal_s;
    logic             blank_s;
    logic [3:0]       digit_s;
    logic             xfer_s;

    // Stability tracking, acceptance strobe and pattern classification.
    always_comb begin
        same_s    = (leds == s_r);
        accept_s  = same_s && (run_r == RUN_LAST);
        dec_s     = seg_decode(leds);
        legal_s   = dec_s[4];
        digit_s   = dec_s[3:0];
        blank_s   = (leds == BLANK);
        xfer_s    = out_valid_r && dig.out_ready;
        run_nxt_s = RUN_ONE;
        if (same_s) begin
            if (run_r == RUN_MAX) begin
                run_nxt_s = RUN_MAX;
            end else begin
                run_nxt_s = run_r + RUN_ONE;
            end
        end else begin
            run_nxt_s = RUN_ONE;
        end
    end

    // Sample history, digit slot, error counter and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s_r         <= BLANK;
            run_r       <= RUN_ZERO;
            bcd_r       <= 4'd0;
            out_valid_r <= 1'b0;
            invalid_r   <= 1'b0;
            err_count_r <= {CNT_W{1'b0}};
            overrun_r   <= 1'b0;
        end else begin
            s_r       <= leds;
            run_r     <= run_nxt_s;
            invalid_r <= 1'b0;
            if (accept_s && legal_s) begin
                // Slot is free if empty or being drained this very cycle.
                if (!out_valid_r || dig.out_ready) begin
                    bcd_r       <= digit_s;
                    out_valid_r <= 1'b1;
                end else begin
                    overrun_r <= 1'b1;
                end
            end else begin
                if (accept_s && !blank_s) begin
                    invalid_r <= 1'b1;
                    if (err_count_r != CNT_MAX) begin
                        err_count_r <= err_count_r + CNT_ONE;
                    end else begin
                        err_count_r <= CNT_MAX;
                    end
                end else begin
                    invalid_r <= 1'b0;
                end
                if (xfer_s) begin
                    out_valid_r <= 1'b0;
                end else begin
                    out_valid_r <= out_valid_r;
                end
            end
        end
    end

    assign dig.bcd       = bcd_r;
    assign dig.out_valid = out_valid_r;
    assign invalid       = invalid_r;
    assign err_count     = err_count_r;
    assign overrun       = overrun_r;

endmodule

// File: doc/seg7_decoder.md
Name: seg7_decoder

Overview:
- Inverse of the team's BCD-to-seven-segment encoder: samples an active-low 7-segment pattern bus (segment order g..a, bit 6 = g) and recovers the BCD digit.
- Used for loopback self-checks of display paths and for reading digit patterns from a peer board.
- Filters glitches by requiring the pattern to be stable for a number of cycles. Flags illegal patterns.
- Delivers each decoded digit once over a valid/ready handshake.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples needed to accept a pattern. Legal range is 2 or more; the stability counter saturates at this value.
- CNT_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low; reset==0 at a rising edge resets all state.
- leds  input  7  active-low segment pattern, bit 6 = g ... bit 0 = a.
- bcd  output  4  decoded digit; valid while out_valid=1.
- out_valid  output  1  a decoded digit is pending.
- out_ready  input  1  consumer accepts the digit when out_valid && out_ready.
- invalid  output  1  one-cycle pulse when a stable, illegal pattern is accepted.
- err_count  output  CNT_W  number of illegal patterns accepted; saturates at all-ones.
- overrun  output  1  sticky; set when an accepted digit is dropped. Cleared only by reset.

Behaviour:
- Reset values:
  - s = 7'b1111111, run = 0, bcd = 0, out_valid = 0, invalid = 0, err_count = 0, overrun = 0.
  - A reset mid-operation discards any pending digit and the stability history.
- Sampling, every edge:
  - s <= leds.
  - run <= (leds == s) ? min(run + 1, STABLE_CYCLES) : 1.
- accept = (leds == s) && (run == STABLE_CYCLES - 1):
  - Fires exactly once per stable run.
  - A pattern held indefinitely is never re-accepted until it changes.
  - The same digit returning after a different pattern is accepted again.
- Latency: pattern first captured at edge 0 and held → outputs update at edge STABLE_CYCLES-1.
- Decode table (leds → bcd):
  - 1000000 → 0, 1111001 → 1, 0100100 → 2, 0110000 → 3, 0011001 → 4
  - 0010010 → 5, 0000010 → 6, 1111000 → 7, 0000000 → 8, 0010000 → 9
- On accept of 1111111 (blank): no action and no error.
- On accept of any other pattern not in the table: invalid = 1 for one cycle, err_count += 1 (saturating), out_valid unaffected.
- On accept of a legal digit:
  - If out_valid == 0, or out_ready == 1 this cycle: bcd <= digit, out_valid <= 1.
  - Else (pending and stalled): digit dropped, overrun <= 1, bcd unchanged.
- Handshake:
  - out_valid && out_ready with no accept in the same cycle → out_valid <= 0.
  - bcd and out_valid are held constant while out_valid && !out_ready.
- All outputs are registered; no combinational path from leds to any output.

Optional Feature:
- Macro: SEG7_DECODER_HEX_EN.
- Defined: these patterns are legal, in addition to 0–9:
  - 0001000 → A, 0000011 → b, 1000110 → C, 0100001 → d, 0000110 → E, 0001110 → F
  - Each yields bcd 10–15.
- Undefined: those patterns are illegal (invalid pulse, err_count increments).
- Port list is identical in both builds.

Test Plan (STABLE_CYCLES = 4, CNT_W = 8):
1. reset = 0 for 2 edges, then reset = 1, leds = 1111111 held 20 cycles → out_valid = 0, invalid = 0, err_count = 0, overrun = 0 throughout.
2. leds = 0110000 first captured at edge 0 and held 12 cycles, out_ready = 1 → out_valid high only in the cycle after edge 3 with bcd = 3; no further outputs.
3. leds = 0010010 for 3 cycles, then 0000010 held → no output for the first pattern; exactly one output with bcd = 6, 4 edges after the change.
4. leds = 0110110 held → one invalid pulse, err_count = 1, out_valid stays 0. Alternate with blank 300 times → err_count saturates at 255.
5. out_ready = 0; digit 2 accepted, then digit 7 accepted → bcd stays 2, overrun = 1. Set out_ready = 1 → one transfer of 2, then out_valid = 0, overrun remains 1.
6. Digit pending with out_ready = 0; reset = 0 for one edge → out_valid = 0, err_count = 0, overrun = 0. With SEG7_DECODER_HEX_EN, leds = 0001000 → bcd = 10; without it → invalid pulse.
